// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared constants and helpers for the multi-port register file.
//   RF_DATA_W / RF_DEPTH / RF_NUM_RD : default geometry (32 x 32, two reads)
//   slice_lo()                       : low bit of slice <idx> in a packed bus
//                                      made of equal <width>-bit fields
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_NUM_RD = 2;

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One synchronous read port of regfile_multiport. Selects the addressed
// register (with zero-register and write-bypass handling), derives the busy
// flag from the scoreboard and registers both when re_i is high.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   re_i          : read enable (captures data/busy at the rising edge)
//   raddr_i       : register address for this port
//   we_i, waddr_i, wdata_i : same-cycle write, used for bypass / busy hiding
//   regs_flat_i   : all registers, register r at [r*DATA_W +: DATA_W]
//   pending_i     : scoreboard vector
//   rdata_o       : registered read data
//   rbusy_o       : registered pending flag for raddr_i
// ---------------------------------------------------------------------------
module regfile_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    re_i,
    input  logic [ADDR_W-1:0]       raddr_i,
    input  logic                    we_i,
    input  logic [ADDR_W-1:0]       waddr_i,
    input  logic [DATA_W-1:0]       wdata_i,
    input  logic [DEPTH*DATA_W-1:0] regs_flat_i,
    input  logic [DEPTH-1:0]        pending_i,
    output logic [DATA_W-1:0]       rdata_o,
    output logic                    rbusy_o
);

    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              rbusy_d, rbusy_q;
    logic              wr_hit;

    assign wr_hit = we_i && (waddr_i == raddr_i);

    // Priority: zero register, then bypassed write data, then stored value.
    always_comb begin
        rdata_d = regs_flat_i[slice_lo(int'(raddr_i), DATA_W) +: DATA_W];
        if ((BYPASS != 0) && wr_hit) begin
            rdata_d = wdata_i;
        end
        if ((ZERO_REG != 0) && (raddr_i == '0)) begin
            rdata_d = '0;
        end
    end

    // A writeback landing this cycle retires the pending producer, so the
    // reader should not stall on it (matches the bypassed data).
    always_comb begin
        rbusy_d = pending_i[raddr_i] & ~wr_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            rbusy_q <= 1'b0;
        end else if (re_i) begin
            rdata_q <= rdata_d;
            rbusy_q <= rbusy_d;
        end
    end

    assign rdata_o = rdata_q;
    assign rbusy_o = rbusy_q;

endmodule

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
// Register file with NUM_RD synchronous read ports, one write port and a
// per-register pending scoreboard for decode-stage hazard detection.
// Ports:
//   clk, reset_n       : clock, asynchronous active-low reset
//   re                 : read enable shared by all read ports
//   raddr              : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata              : packed registered read data, port k at [k*DATA_W +: DATA_W]
//   rvalid             : rdata/rbusy were updated by the last edge
//   rbusy              : per-port registered pending flag
//   we, waddr, wdata   : write port
//   pend_set, pend_addr: mark a register as awaiting writeback
//   pending            : scoreboard vector straight from the flops
//
// Read handshake: there is no back-pressure. Sampling re=1 at edge t
// loads rdata/rbusy at t and raises rvalid for exactly the following cycle;
// with re=0 rdata/rbusy hold and rvalid is 0.
// ---------------------------------------------------------------------------
module regfile_multiport
    import rf_pkg::*;
#(
    parameter  int DATA_W   = RF_DATA_W,
    parameter  int DEPTH    = RF_DEPTH,
    parameter  int NUM_RD   = RF_NUM_RD,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     rvalid,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic [DEPTH-1:0]         pending
);

    logic [DATA_W-1:0]       mem_q [DEPTH];
    logic [DEPTH*DATA_W-1:0] regs_flat;
    logic [DEPTH-1:0]        pending_d, pending_q;
    logic                    rvalid_q;
    logic                    wr_en;

    // ---------------- storage and write port ----------------
    assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wr_en) begin
            mem_q[waddr] <= wdata;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign regs_flat[slice_lo(g, DATA_W) +: DATA_W] = mem_q[g];
    end

    // ---------------- scoreboard ----------------
    // Set is applied after clear so a new producer issued in the same cycle
    // as the previous producer's writeback keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (we) begin
            pending_d[waddr] = 1'b0;
        end
        if (pend_set) begin
            pending_d[pend_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

    // ---------------- read ports ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= re;
        end
    end

    assign rvalid = rvalid_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .DEPTH    (DEPTH),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .clk         (clk),
            .reset_n     (reset_n),
            .re_i        (re),
            .raddr_i     (raddr[slice_lo(k, ADDR_W) +: ADDR_W]),
            .we_i        (we),
            .waddr_i     (waddr),
            .wdata_i     (wdata),
            .regs_flat_i (regs_flat),
            .pending_i   (pending_q),
            .rdata_o     (rdata[slice_lo(k, DATA_W) +: DATA_W]),
            .rbusy_o     (rbusy[k])
        );
    end

endmodule

// File: tb/tb_regfile_multiport.sv
`timescale 1ns/100ps
module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int DEPTH = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic re, we, pend_set;
    logic [NR*AW-1:0] raddr;
    logic [AW-1:0] waddr, pend_addr;
    logic [DW-1:0] wdata;

    // instance a: ZERO_REG=1, BYPASS=1 ; instance b: ZERO_REG=0, BYPASS=0
    logic [NR*DW-1:0] rdata_a, rdata_b;
    logic rvalid_a, rvalid_b;
    logic [NR-1:0] rbusy_a, rbusy_b;
    logic [DEPTH-1:0] pending_a, pending_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_multiport #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .re(re), .raddr(raddr), .rdata(rdata_a),
        .rvalid(rvalid_a), .rbusy(rbusy_a), .we(we), .waddr(waddr), .wdata(wdata),
        .pend_set(pend_set), .pend_addr(pend_addr), .pending(pending_a));

    regfile_multiport #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NR), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .re(re), .raddr(raddr), .rdata(rdata_b),
        .rvalid(rvalid_b), .rbusy(rbusy_b), .we(we), .waddr(waddr), .wdata(wdata),
        .pend_set(pend_set), .pend_addr(pend_addr), .pending(pending_b));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0]    m_reg [2][DEPTH];
    logic [DEPTH-1:0] m_pend [2];
    logic [DW-1:0]    e_rdata [2][NR];
    logic             e_rbusy [2][NR];
    logic             e_rvalid [2];

    always @(posedge clk or negedge reset_n) begin : model
        int a;
        bit zr, bp;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = '0;
                e_rvalid[i] = 1'b0;
                for (int k = 0; k < NR; k++) begin
                    e_rdata[i][k] = '0;
                    e_rbusy[i][k] = 1'b0;
                end
                for (int r = 0; r < DEPTH; r++) m_reg[i][r] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                zr = (i == 0);
                bp = (i == 0);
                e_rvalid[i] = re;
                if (re) begin
                    for (int k = 0; k < NR; k++) begin
                        a = int'(raddr[k*AW +: AW]);
                        if (zr && a == 0) e_rdata[i][k] = '0;
                        else if (bp && we && int'(waddr) == a) e_rdata[i][k] = wdata;
                        else e_rdata[i][k] = m_reg[i][a];
                        e_rbusy[i][k] = m_pend[i][a] && !(we && int'(waddr) == a);
                    end
                end
                if (we && !(zr && waddr == 0)) m_reg[i][waddr] = wdata;
                if (we) m_pend[i][waddr] = 1'b0;
                if (pend_set) m_pend[i][pend_addr] = 1'b1;
                if (zr) m_pend[i][0] = 1'b0;
            end
        end
    end

    task automatic cmp_inst(input int i, input logic rv, input logic [NR*DW-1:0] rd,
                            input logic [NR-1:0] rb, input logic [DEPTH-1:0] pd);
        chk($sformatf("i%0d_rvalid", i), 64'(rv), 64'(e_rvalid[i]));
        for (int k = 0; k < NR; k++) begin
            chk($sformatf("i%0d_rdata%0d", i, k), 64'(rd[k*DW +: DW]), 64'(e_rdata[i][k]));
            chk($sformatf("i%0d_rbusy%0d", i, k), 64'(rb[k]), 64'(e_rbusy[i][k]));
        end
        chk($sformatf("i%0d_pending", i), 64'(pd), 64'(m_pend[i]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, rvalid_a, rdata_a, rbusy_a, pending_a);
        cmp_inst(1, rvalid_b, rdata_b, rbusy_b, pending_b);
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        re = 1'b0; we = 1'b0; pend_set = 1'b0;
        raddr = '0; waddr = '0; wdata = '0; pend_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
        re = 1'b1;
        raddr = {a1, a0};
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
    endtask

    task automatic pset(input logic [AW-1:0] a);
        pend_set = 1'b1;
        pend_addr = a;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        idle();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_rdata", 64'(rdata_a), 64'h0);
        chk("reset_rvalid", 64'(rvalid_a), 64'h0);
        chk("reset_pending", 64'(pending_a), 64'h0);

        // first read after reset
        idle(); rd(5'd5, 5'd3); tick();
        chk("rst_read_rdata", 64'(rdata_a), 64'h0);
        chk("rst_read_rvalid", 64'(rvalid_a), 64'h1);
        chk("rst_read_rbusy", 64'(rbusy_a), 64'h0);

        // write then read back
        idle(); wr(5'd5, 32'hDEADBEEF); tick();
        chk("no_re_rvalid", 64'(rvalid_a), 64'h0);
        idle(); rd(5'd0, 5'd5); tick();
        chk("wr5_rd_a", 64'(rdata_a[31:0]), 64'hDEADBEEF);
        chk("wr5_rd_b", 64'(rdata_b[31:0]), 64'hDEADBEEF);

        // same-cycle write/read on both ports
        idle(); wr(5'd7, 32'h12345678); rd(5'd7, 5'd7); tick();
        chk("bypass_a", 64'(rdata_a), 64'h12345678_12345678);
        chk("nobypass_b", 64'(rdata_b), 64'h0);
        idle(); rd(5'd7, 5'd7); tick();
        chk("after_wr_b", 64'(rdata_b), 64'h12345678_12345678);

        // zero register
        idle(); wr(5'd0, 32'hFFFFFFFF); tick();
        idle(); rd(5'd0, 5'd0); tick();
        chk("zero_reg_a", 64'(rdata_a), 64'h0);
        chk("reg0_b", 64'(rdata_b), 64'hFFFFFFFF_FFFFFFFF);

        // scoreboard
        idle(); pset(5'd9); tick();
        chk("pend9_set", 64'(pending_a[9]), 64'h1);
        idle(); rd(5'd0, 5'd9); tick();
        chk("rbusy9", 64'(rbusy_a), 64'h1);
        idle(); tick();
        chk("hold_rbusy", 64'(rbusy_a), 64'h1);
        chk("hold_rvalid", 64'(rvalid_a), 64'h0);
        chk("hold_rdata", 64'(rdata_a[31:0]), 64'h0);
        idle(); wr(5'd9, 32'h55AA55AA); pset(5'd9); rd(5'd9, 5'd9); tick();
        chk("set_wins", 64'(pending_a[9]), 64'h1);
        chk("wb_hides_busy", 64'(rbusy_a), 64'h0);
        chk("wb_bypass", 64'(rdata_a), 64'h55AA55AA_55AA55AA);
        idle(); rd(5'd0, 5'd9); tick();
        chk("reset_visible", 64'(rbusy_a), 64'h1);
        idle(); wr(5'd9, 32'h0000_0009); tick();
        chk("pend9_clear", 64'(pending_a[9]), 64'h0);
        idle(); pset(5'd12); tick();
        idle(); wr(5'd12, 32'h1); pset(5'd13); tick();
        chk("set_clr_diff", 64'(pending_a[13:12]), 64'h2);
        idle(); pset(5'd0); tick();
        chk("pend0_a", 64'(pending_a[0]), 64'h0);
        chk("pend0_b", 64'(pending_b[0]), 64'h1);

        // mid-cycle reset drops state and the in-flight read
        for (int i = 1; i <= 4; i++) begin
            idle(); wr(AW'(i), 32'hA0 + DW'(i)); tick();
        end
        idle(); rd(5'd2, 5'd1); tick();
        chk("pre_rst_rdata", 64'(rdata_a), 64'h000000A2_000000A1);
        idle(); rd(5'd4, 5'd3);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #0.5;
        chk("in_rst_rvalid_a", 64'(rvalid_a), 64'h0);
        chk("in_rst_rvalid_b", 64'(rvalid_b), 64'h0);
        chk("in_rst_rdata", 64'(rdata_a), 64'h0);
        chk("in_rst_pending", 64'(pending_b), 64'h0);
        #0.5 reset_n = 1'b1;
        idle(); rd(5'd2, 5'd1); tick();
        chk("post_rst_12", 64'(rdata_a), 64'h0);
        chk("post_rst_rvalid", 64'(rvalid_a), 64'h1);
        idle(); rd(5'd4, 5'd3); tick();
        chk("post_rst_34", 64'(rdata_b), 64'h0);

        // mixed traffic on a narrow address range to force collisions
        for (int n = 0; n < 80; n++) begin
            re = 1'($urandom_range(0, 1));
            raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 7));
            wdata = $urandom;
            pend_set = 1'($urandom_range(0, 1));
            pend_addr = 5'($urandom_range(0, 7));
            tick();
        end

        idle();
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the 32x32 single-read-pair register file for the MIPS datapath.
- Provides NUM_RD synchronous read ports and one write port.
- Reads and writes are independent in the same cycle, with optional write-to-read bypass and an optional hardwired zero register.
- A per-register pending scoreboard supports pipeline hazard detection in decode.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; must be a power of 2, >= 2.
- ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- re  in  1  read enable, shared by all read ports.
- raddr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  packed registered read data.
- rvalid  out  1  rdata updated this cycle (registered re).
- rbusy  out  NUM_RD  per-port pending flag, registered with rdata.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- pend_set  in  1  mark pend_addr as awaiting writeback.
- pend_addr  in  ADDR_W  register being issued to.
- pending  out  DEPTH  current scoreboard vector, direct from flops.

Behaviour:
- Reset (async assert, sync-safe release):
  - all registers = 0, rdata = 0, rvalid = 0, rbusy = 0, pending = 0.
- Write:
  - we=1 at edge t updates reg[waddr] at t.
  - When ZERO_REG=1 and waddr=0, the write is dropped.
- Read, 1-cycle latency:
  - re=1 in cycle t gives rdata_k / rbusy_k valid after edge t, with rvalid=1 for one cycle.
  - re=0 leaves rdata and rbusy holding their last values and drives rvalid=0.
- Read data select, per port k:
  - If ZERO_REG and raddr_k=0, returns 0.
  - Else if BYPASS and we and waddr==raddr_k, returns wdata.
  - Else returns reg[raddr_k] (pre-write value).
  - With BYPASS=0, a same-address read/write returns the old value.
- Multiple read ports may read the same address; each independently obeys the rules above.
- Scoreboard update at each edge:
  - we clears pending[waddr].
  - pend_set sets pending[pend_addr].
  - Set and clear to the same address in the same cycle: set wins (new producer issued).
  - Set and clear to different addresses both apply.
  - With ZERO_REG, bit 0 is forced to 0.
- rbusy_k = pending[raddr_k] & ~(we & waddr==raddr_k).
  - Same-cycle writeback hides the busy flag, consistent with bypass.
  - A same-cycle pend_set is not visible until the next read.
- Reset asserted mid-operation: all state clears immediately; the in-flight read is lost and rvalid drops to 0.
- Addresses are full-range (DEPTH = 2^ADDR_W); no out-of-range case exists.

Decomposition:
- rf_pkg holds:
  - default constants RF_DATA_W=32, RF_DEPTH=32, RF_NUM_RD=2;
  - helper function for packed-slice index calculation.
- Sub-module regfile_read_port (one per read port, via generate) contains:
  - address mux, zero-reg check, bypass compare;
  - rdata/rbusy output flops.
- The top level owns the storage array, the write logic and the scoreboard.

Test Plan:
- Reset then re=1, raddr={5,3} -> next cycle rdata={0,0}, rvalid=1, rbusy=0, pending=0.
- we=1, waddr=5, wdata=32'hDEADBEEF; next cycle re=1, raddr0=5 -> rdata0=32'hDEADBEEF.
- Same cycle we=1, waddr=7, wdata=32'h12345678, re=1, raddr={7,7}:
  - BYPASS=1 -> both ports 32'h12345678;
  - BYPASS=0 -> both ports the old value 0.
- we=1, waddr=0, wdata=32'hFFFFFFFF, then read reg 0 -> rdata=0 (ZERO_REG=1).
- Scoreboard:
  - pend_set, pend_addr=9 -> pending[9]=1;
  - read 9 -> rbusy=1;
  - same cycle we to 9 and pend_set to 9 -> pending[9] stays 1;
  - we to 9 alone -> pending[9]=0.
- Write regs 1..4 with 32'hA1..A4, assert reset_n=0 for 1 ns mid-cycle, then read 1..4 -> all 0, rvalid=0 during reset.
